// File: rtl/serial_adder_n_pkg.sv
// Shared definitions for the serial adder: FSM state encoding and the
// counter-width helper.
package serial_adder_n_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Digit counter width: enough bits to count 0..n-1, never less than one.
  function automatic int CNT_W(input int n);
    if (n <= 1) begin
      return 1;
    end
    return $clog2(n);
  endfunction

endpackage

// File: rtl/serial_adder_n_fulladder.sv
// Single-bit full adder cell, used as one link of the per-digit ripple chain.
module serial_adder_n_fulladder (
  input  logic x_i,
  input  logic y_i,
  input  logic cin_i,
  output logic a_o,
  output logic cout_o
);

  assign a_o    = x_i ^ y_i ^ cin_i;
  assign cout_o = (x_i & y_i) | (cin_i & (x_i ^ y_i));

endmodule

// File: rtl/serial_adder_n.sv
// Multi-cycle adder: adds two WIDTH-bit operands plus carry-in, DIGIT bits
// per clock, through a ripple chain of DIGIT full adders and a registered
// carry. One add takes WIDTH/DIGIT RUN cycles.
//
// Handshake: start is sampled only while busy==0 (IDLE or DONE). An accepted
// start captures a/b/cin; busy is high for the RUN cycles; done pulses for
// exactly one cycle when sum/cout/overflow are updated, and those outputs
// hold until the next done. A start seen while busy==1 is dropped.
module serial_adder_n
  import serial_adder_n_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic [1:0]       state_o
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = CNT_W(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  // Configuration sanity checks at elaboration.
  if (WIDTH % DIGIT != 0) begin : g_bad_digit
    $error("serial_adder_n: DIGIT must divide WIDTH");
  end
  if (WIDTH < 2) begin : g_bad_width
    $error("serial_adder_n: WIDTH must be at least 2");
  end

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;

  logic [DIGIT:0]   chain_c;
  logic [DIGIT-1:0] chain_s;
  logic [WIDTH-1:0] a_d;
  logic [WIDTH-1:0] b_d;

  // Ripple chain over the low DIGIT bits of the operand shift registers.
  assign chain_c[0] = carry_q;
  for (genvar i = 0; i < DIGIT; i++) begin : g_chain
    serial_adder_n_fulladder u_fa (
      .x_i    (a_q[i]),
      .y_i    (b_q[i]),
      .cin_i  (chain_c[i]),
      .a_o    (chain_s[i]),
      .cout_o (chain_c[i+1])
    );
  end

  // The A shift register doubles as the result accumulator: each digit's
  // sum enters at the MSB end while the consumed operand digit leaves at the
  // LSB end, so after N shifts it holds the complete sum.
  if (DIGIT == WIDTH) begin : g_acc_full
    assign a_d = chain_s;
  end else begin : g_acc_part
    assign a_d = {chain_s, a_q[WIDTH-1:DIGIT]};
  end
  assign b_d = b_q >> DIGIT;

  // Control FSM plus datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          a_q     <= a_d;
          b_q     <= b_d;
          carry_q <= chain_c[DIGIT];
          if (cnt_q == CNT_LAST) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            sum_q   <= a_d;
            cout_q  <= chain_c[DIGIT];
            ovf_q   <= chain_c[DIGIT-1] ^ chain_c[DIGIT];
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;
  assign state_o  = state_q;

endmodule
